// File: rtl/window_gen_3x3.sv
// window_gen_3x3: streaming 3x3 neighbourhood generator.
// Two parity-indexed line buffers feed a 3-column window shift register.
module window_gen_3x3 #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 256,
  parameter int IMG_H = 256
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       pad_mode,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PIX_W-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [9*PIX_W-1:0]         win_data,
  output logic [$clog2(IMG_H)-1:0]   out_row,
  output logic [$clog2(IMG_W)-1:0]   out_col,
  output logic                       out_last
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int IW = $clog2(IMG_H + 1);
  localparam logic [CW-1:0] C_MAX  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] R_MAX  = RW'(IMG_H - 1);
  localparam logic [IW-1:0] I_LAST = IW'(IMG_H - 1);
  localparam logic [IW-1:0] I_VIRT = IW'(IMG_H);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t state_q, state_d;
  logic start_q, start_d;
  logic [IW-1:0] ir_q, ir_d;
  logic [CW-1:0] ic_q, ic_d;
  logic pend_q, pend_d;
  logic mode_q, mode_d;
  logic [2:0][PIX_W-1:0] ct_q, ct_d;
  logic [2:0][PIX_W-1:0] cm_q, cm_d;
  logic [2:0][PIX_W-1:0] cb_q, cb_d;
  logic ov_q, ov_d;
  logic [9*PIX_W-1:0] win_q, win_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic last_q, last_d;

  logic [PIX_W-1:0] lb0_q [IMG_W];
  logic [PIX_W-1:0] lb1_q [IMG_W];

  logic slot_free, acc, vstep, step;
  logic pend_go, shift, load;
  logic [PIX_W-1:0] rd0, rd1, top_px, mid_px;
  logic [2:0][PIX_W-1:0] sh_t, sh_m, sh_b;
  logic [2:0][PIX_W-1:0] vt, vm, vb;
  logic [RW-1:0] wrow;
  logic [CW-1:0] wcol;
  logic [9*PIX_W-1:0] win_nxt;

  assign slot_free = !ov_q || out_ready;
  assign in_ready  = start_q && (state_q != FLUSH)
                   && !pend_q && slot_free;
  assign acc       = in_valid && in_ready;
  // Past the last real row, a virtual row replays the buffers.
  assign vstep     = (state_q == FLUSH) && (ir_q == I_VIRT)
                   && !pend_q && slot_free;
  assign step      = acc || vstep;
  assign pend_go   = pend_q && slot_free;
  assign shift     = step || pend_go;
  assign load      = (step && ir_q != '0 && ic_q != '0) || pend_go;

  // Row ir-2 shares parity with row ir, so it sits in the slot we write.
  assign rd0    = lb0_q[ic_q];
  assign rd1    = lb1_q[ic_q];
  assign top_px = ir_q[0] ? rd1 : rd0;
  assign mid_px = ir_q[0] ? rd0 : rd1;

  assign sh_t = {top_px, ct_q[2:1]};
  assign sh_m = {mid_px, cm_q[2:1]};
  assign sh_b = {in_data, cb_q[2:1]};

  assign wrow = pend_q ? row_q : RW'(ir_q - IW'(1));
  assign wcol = pend_q ? C_MAX : ic_q - CW'(1);

  always_comb begin
    vt = '0;
    vm = '0;
    vb = '0;
    for (int j = 0; j < 3; j++) begin
      vm[j] = sh_m[j];
      vt[j] = (wrow == '0) ?
              (mode_q ? sh_m[j] : '0) : sh_t[j];
      vb[j] = (wrow == R_MAX) ?
              (mode_q ? sh_m[j] : '0) : sh_b[j];
    end
    if (wcol == '0) begin
      vt[0] = mode_q ? vt[1] : '0;
      vm[0] = mode_q ? vm[1] : '0;
      vb[0] = mode_q ? vb[1] : '0;
    end
    if (wcol == C_MAX) begin
      vt[2] = mode_q ? vt[1] : '0;
      vm[2] = mode_q ? vm[1] : '0;
      vb[2] = mode_q ? vb[1] : '0;
    end
    win_nxt = {vb, vm, vt};
  end

  always_comb begin
    state_d = state_q;
    start_d = 1'b1;
    ir_d    = ir_q;
    ic_d    = ic_q;
    pend_d  = pend_q;
    mode_d  = mode_q;
    ct_d    = ct_q;
    cm_d    = cm_q;
    cb_d    = cb_q;
    ov_d    = ov_q && !out_ready;
    win_d   = win_q;
    row_d   = row_q;
    col_d   = col_q;
    last_d  = last_q;
    if (shift) begin
      ct_d = sh_t;
      cm_d = sh_m;
      cb_d = sh_b;
    end
    if (load) begin
      ov_d   = 1'b1;
      win_d  = win_nxt;
      row_d  = wrow;
      col_d  = wcol;
      last_d = (wrow == R_MAX) && (wcol == C_MAX);
    end
    if (step) begin
      pend_d = (ir_q != '0) && (ic_q == C_MAX);
      if (ic_q == C_MAX) begin
        ic_d = '0;
        ir_d = (ir_q == I_VIRT) ? '0 : ir_q + IW'(1);
      end else begin
        ic_d = ic_q + CW'(1);
      end
    end
    if (pend_go) pend_d = 1'b0;
    if (acc && state_q == IDLE) mode_d = pad_mode;
    unique case (state_q)
      IDLE: if (acc) state_d = RUN;
      RUN: begin
        if (acc && ir_q == I_LAST && ic_q == C_MAX)
          state_d = FLUSH;
      end
      FLUSH: begin
        if (ov_q && out_ready && last_q)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      ir_q    <= '0;
      ic_q    <= '0;
      pend_q  <= 1'b0;
      mode_q  <= 1'b0;
      ct_q    <= '0;
      cm_q    <= '0;
      cb_q    <= '0;
      ov_q    <= 1'b0;
      win_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      ir_q    <= ir_d;
      ic_q    <= ic_d;
      pend_q  <= pend_d;
      mode_q  <= mode_d;
      ct_q    <= ct_d;
      cm_q    <= cm_d;
      cb_q    <= cb_d;
      ov_q    <= ov_d;
      win_q   <= win_d;
      row_q   <= row_d;
      col_q   <= col_d;
      last_q  <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (acc && !ir_q[0]) lb0_q[ic_q] <= in_data;
    if (acc && ir_q[0])  lb1_q[ic_q] <= in_data;
  end

  assign out_valid = ov_q;
  assign win_data  = win_q;
  assign out_row   = row_q;
  assign out_col   = col_q;
  assign out_last  = last_q;
endmodule

// File: tb/tb_window_gen_3x3.sv
// tb_window_gen_3x3: directed 4x3 window tables plus a
// 256x256 scoreboard run on a second instance.
module tb_window_gen_3x3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic s_pad, s_in_valid, s_in_ready, s_out_valid;
  logic s_out_ready, s_last;
  logic [7:0] s_in_data;
  logic [71:0] s_win;
  logic [1:0] s_row, s_col;

  logic b_pad, b_in_valid, b_in_ready, b_out_valid;
  logic b_out_ready, b_last;
  logic [7:0] b_in_data;
  logic [71:0] b_win;
  logic [7:0] b_row, b_col;

  window_gen_3x3 #(.PIX_W(8), .IMG_W(4), .IMG_H(3)) dut (
    .clk(clk), .rst_n(rst_n), .pad_mode(s_pad),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .win_data(s_win),
    .out_row(s_row), .out_col(s_col), .out_last(s_last)
  );

  window_gen_3x3 dut_big (
    .clk(clk), .rst_n(rst_n), .pad_mode(b_pad),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .win_data(b_win),
    .out_row(b_row), .out_col(b_col), .out_last(b_last)
  );

  typedef struct packed {
    logic pad;
    logic [71:0] win;
  } vec_t;

  typedef struct packed {
    logic [71:0] win;
    logic [1:0] row;
    logic [1:0] col;
    logic last;
  } obs_t;

  vec_t tbl [24];
  obs_t gq [$];
  int acc_cyc [$];
  int last_cyc [$];
  logic [7:0] img [65536];
  int nvec = 0;
  int nbad = 0;

  function automatic logic [71:0] mkw(
    input int k0, input int k1, input int k2,
    input int k3, input int k4, input int k5,
    input int k6, input int k7, input int k8);
    return {8'(k8), 8'(k7), 8'(k6), 8'(k5), 8'(k4),
            8'(k3), 8'(k2), 8'(k1), 8'(k0)};
  endfunction

  task automatic chk(input string nm,
                     input logic [95:0] act,
                     input logic [95:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic obs_t cur_obs();
    obs_t o;
    o.win  = s_win;
    o.row  = s_row;
    o.col  = s_col;
    o.last = s_last;
    return o;
  endfunction

  task automatic run_stream(input int npix, input bit bp,
                            input int nwin, input logic pad0);
    int sent = 0;
    int cyc = 0;
    bit hold_v = 1'b0;
    obs_t held = '0;
    bit [3:0] pat = 4'b1001;
    while ((sent < npix || gq.size() < nwin) && cyc < 400) begin
      s_in_valid  = (sent < npix);
      s_in_data   = 8'((sent % 12) + 1);
      s_pad       = (sent >= 12) ? ~pad0 : pad0;
      s_out_ready = bp ? pat[cyc % 4] : 1'b1;
      @(negedge clk);
      if (hold_v)
        chk("hold_stable", 96'({s_out_valid, cur_obs()}),
            96'({1'b1, held}));
      hold_v = s_out_valid && !s_out_ready;
      if (hold_v) begin
        held = cur_obs();
        chk("in_ready_full", 96'(s_in_ready), 96'(0));
      end
      if (s_in_valid && s_in_ready) begin
        acc_cyc.push_back(cyc);
        sent++;
      end
      if (s_out_valid && s_out_ready) begin
        gq.push_back(cur_obs());
        if (s_last) last_cyc.push_back(cyc);
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    if (cyc >= 400) chk("stream_timeout", 96'(cyc), 96'(0));
    s_in_valid  = 1'b0;
    s_out_ready = 1'b1;
  endtask

  task automatic check_frame(input int base, input logic rep);
    int i = 0;
    for (int j = 0; j < 24; j++) begin
      if (tbl[j].pad == rep) begin
        obs_t g;
        obs_t e;
        g = (base + i < gq.size()) ? gq[base + i] : '0;
        e.win  = tbl[j].win;
        e.row  = 2'(i / 4);
        e.col  = 2'(i % 4);
        e.last = (i == 11);
        chk($sformatf("win%0d_pad%0d", base + i, rep),
            96'(g), 96'(e));
        i++;
      end
    end
  endtask

  function automatic logic [71:0] exp_big(input int r,
                                          input int c,
                                          input logic m);
    logic [71:0] w;
    w = '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        int rr;
        int cc;
        bit oob;
        rr = r + dr;
        cc = c + dc;
        oob = 1'b0;
        if (rr < 0)   begin rr = 0;   oob = 1'b1; end
        if (rr > 255) begin rr = 255; oob = 1'b1; end
        if (cc < 0)   begin cc = 0;   oob = 1'b1; end
        if (cc > 255) begin cc = 255; oob = 1'b1; end
        w[((dr + 1) * 3 + (dc + 1)) * 8 +: 8] =
          (oob && !m) ? 8'h00 : img[rr * 256 + cc];
      end
    end
    return w;
  endfunction

  task automatic run_big();
    int sent = 0;
    int got = 0;
    int cyc = 0;
    int c0 = -1;
    int cl = -1;
    int r;
    int c;
    b_pad = 1'b1;
    b_out_ready = 1'b1;
    while (got < 65536 && cyc < 70000) begin
      b_in_valid = (sent < 65536);
      b_in_data  = img[sent % 65536];
      @(negedge clk);
      if (b_in_valid && b_in_ready) begin
        if (c0 < 0) c0 = cyc;
        sent++;
      end
      if (b_out_valid) begin
        r = got / 256;
        c = got % 256;
        chk($sformatf("big(%0d,%0d)", r, c),
            96'({b_row, b_col, b_last, b_win}),
            96'({8'(r), 8'(c), (got == 65535),
                 exp_big(r, c, 1'b1)}));
        if (b_last) cl = cyc;
        got++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    b_in_valid = 1'b0;
    chk("big_count", 96'(got), 96'(65536));
    chk("big_cycles_ok",
        96'(cl >= 0 && (cl - c0) <= 65536 + 256 + 256 + 4),
        96'(1));
  endtask

  initial begin
    tbl[0]  = '{1'b0, mkw(0,0,0, 0,1,2, 0,5,6)};
    tbl[1]  = '{1'b0, mkw(0,0,0, 1,2,3, 5,6,7)};
    tbl[2]  = '{1'b0, mkw(0,0,0, 2,3,4, 6,7,8)};
    tbl[3]  = '{1'b0, mkw(0,0,0, 3,4,0, 7,8,0)};
    tbl[4]  = '{1'b0, mkw(0,1,2, 0,5,6, 0,9,10)};
    tbl[5]  = '{1'b0, mkw(1,2,3, 5,6,7, 9,10,11)};
    tbl[6]  = '{1'b0, mkw(2,3,4, 6,7,8, 10,11,12)};
    tbl[7]  = '{1'b0, mkw(3,4,0, 7,8,0, 11,12,0)};
    tbl[8]  = '{1'b0, mkw(0,5,6, 0,9,10, 0,0,0)};
    tbl[9]  = '{1'b0, mkw(5,6,7, 9,10,11, 0,0,0)};
    tbl[10] = '{1'b0, mkw(6,7,8, 10,11,12, 0,0,0)};
    tbl[11] = '{1'b0, mkw(7,8,0, 11,12,0, 0,0,0)};
    tbl[12] = '{1'b1, mkw(1,1,2, 1,1,2, 5,5,6)};
    tbl[13] = '{1'b1, mkw(1,2,3, 1,2,3, 5,6,7)};
    tbl[14] = '{1'b1, mkw(2,3,4, 2,3,4, 6,7,8)};
    tbl[15] = '{1'b1, mkw(3,4,4, 3,4,4, 7,8,8)};
    tbl[16] = '{1'b1, mkw(1,1,2, 5,5,6, 9,9,10)};
    tbl[17] = '{1'b1, mkw(1,2,3, 5,6,7, 9,10,11)};
    tbl[18] = '{1'b1, mkw(2,3,4, 6,7,8, 10,11,12)};
    tbl[19] = '{1'b1, mkw(3,4,4, 7,8,8, 11,12,12)};
    tbl[20] = '{1'b1, mkw(5,5,6, 9,9,10, 9,9,10)};
    tbl[21] = '{1'b1, mkw(5,6,7, 9,10,11, 9,10,11)};
    tbl[22] = '{1'b1, mkw(6,7,8, 10,11,12, 10,11,12)};
    tbl[23] = '{1'b1, mkw(7,8,8, 11,12,12, 11,12,12)};
    for (int i = 0; i < 65536; i++) img[i] = 8'($urandom);

    s_pad = 1'b0; s_in_valid = 1'b0; s_in_data = '0;
    s_out_ready = 1'b1;
    b_pad = 1'b0; b_in_valid = 1'b0; b_in_data = '0;
    b_out_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs",
        96'({s_out_valid, s_in_ready, s_row, s_col,
             s_last, s_win}), 96'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_rst", 96'(s_in_ready), 96'(1));
    @(posedge clk);
    #1;

    gq.delete();
    run_stream(12, 1'b0, 12, 1'b0);
    check_frame(0, 1'b0);

    gq.delete();
    run_stream(12, 1'b0, 12, 1'b1);
    check_frame(0, 1'b1);

    gq.delete();
    run_stream(12, 1'b1, 12, 1'b0);
    check_frame(0, 1'b0);

    gq.delete();
    run_stream(7, 1'b0, 0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_quiet", 96'({s_out_valid, s_in_ready}), 96'(0));
    @(posedge clk);
    @(negedge clk);
    chk("midrst_quiet2", 96'({s_out_valid, s_in_ready}), 96'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    gq.delete();
    run_stream(12, 1'b0, 12, 1'b0);
    check_frame(0, 1'b0);
    begin
      int extra = 0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (s_out_valid) extra++;
      end
      chk("no_extra_windows", 96'(extra), 96'(0));
      @(posedge clk);
      #1;
    end

    gq.delete();
    acc_cyc.delete();
    last_cyc.delete();
    run_stream(24, 1'b0, 24, 1'b0);
    check_frame(0, 1'b0);
    check_frame(12, 1'b1);
    chk("b2b_order",
        96'(acc_cyc.size() >= 13 && last_cyc.size() >= 1
            && acc_cyc[12] > last_cyc[0]), 96'(1));

    run_big();

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nbad);
    $finish;
  end
endmodule

// File: doc/window_gen_3x3.md
Name: window_gen_3x3

Overview:
- Streaming 3x3 neighbourhood generator for the image filter datapath.
- Accepts one raster-order image frame of IMG_W x IMG_H pixels over a valid/ready stream.
- Emits one 3x3 window per image pixel, in raster order of the centre pixel, with border handling selectable at run time.
- Holds two image rows in internal line buffers, so the upstream feed needs no pre-padded storage.

Parameters:
- PIX_W, 8, pixel width in bits.
- IMG_W, 256, image width in pixels (>=3).
- IMG_H, 256, image height in pixels (>=3).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- pad_mode  in  1  border mode: 0 = zero padding, 1 = edge replication; sampled on acceptance of pixel (0,0)
- in_valid  in  1  input pixel valid
- in_ready  out  1  block can accept a pixel
- in_data  in  PIX_W  input pixel
- out_valid  out  1  window valid
- out_ready  in  1  downstream accepts window
- win_data  out  9*PIX_W  window; slice k at [k*PIX_W +: PIX_W], k=0..8 raster order within the window, k=4 is the centre
- out_row  out  clog2(IMG_H)  centre row of the current window
- out_col  out  clog2(IMG_W)  centre column of the current window
- out_last  out  1  high with the window for (IMG_H-1, IMG_W-1)

Behaviour:
- Reset values: in_ready=0 while rst_n low, in_ready=1 on the first cycle after release; out_valid=0, win_data=0, out_row=0, out_col=0, out_last=0; all counters 0.
- Asynchronous reset mid-frame discards the partial frame. The next accepted pixel is (0,0). Line buffer contents need not be cleared.
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - While out_valid=1 and out_ready=0, win_data, out_row, out_col and out_last are held stable.
- Window content: neighbour (r+dr, c+dc), dr,dc in {-1,0,1}. An out-of-image neighbour is 0 in mode 0, or the pixel at the clipped coordinate in mode 1.
- Emission condition: window (r,c) becomes eligible once pixel (min(r+1,IMG_H-1), min(c+1,IMG_W-1)) has been accepted. Windows are emitted strictly in raster order, one per transfer.
- Output register: out_valid rises on the clock edge after the window becomes eligible and the output register is empty or being drained that cycle. A registered output allows back-to-back windows.
- Input stall: in_ready=0 whenever accepting a pixel would overwrite line-buffer data still needed by an unemitted window, or when no output slot is free.
- States:
  - IDLE/FILL: accept row 0 and pixel (1,0); no output yet.
  - RUN: one input pixel and one output window per cycle when unstalled. At most 1 stall cycle per row at the right edge (window (r,IMG_W-1)).
  - FLUSH: entered after pixel (IMG_H-1,IMG_W-1) is accepted. in_ready=0. Remaining windows of rows IMG_H-2 and IMG_H-1 are emitted from the line buffers.
  - Exit from FLUSH: on transfer of the out_last window, go to IDLE; in_ready returns to 1 the next cycle.
- Throughput: with in_valid=1 and out_ready=1 continuously, one frame completes in <= IMG_W*IMG_H + IMG_H + IMG_W + 4 cycles from the first input transfer to the out_last transfer.
- Arithmetic and counters:
  - Address arithmetic and row/column counters wrap exactly at IMG_W/IMG_H; no sentinel or padded addressing.
  - Column counter wraps to 0 after IMG_W-1 and increments the row counter; the row counter wraps to 0 at end of frame.
- pad_mode changes mid-frame are ignored until the next pixel (0,0).
- Simultaneous output transfer and new window eligibility on the same edge loads the next window without a bubble.

Test Plan:
- Zero-pad window check: IMG_W=4, IMG_H=3, pad_mode=0, pixels 1..12 in raster, out_ready=1.
  -> 12 windows; window (0,0) = 0,0,0,0,1,2,0,5,6.
  -> window (1,1) = 1,2,3,5,6,7,9,10,11.
  -> window (2,3) = 7,8,0,11,12,0,0,0,0, with out_last=1 only on that window.
- Replicate window check: same frame with pad_mode=1.
  -> window (0,0) = 1,1,2,1,1,2,5,5,6.
  -> window (2,3) = 7,8,8,11,12,12,11,12,12.
  -> window (0,3) = 3,4,4,3,4,4,7,8,8.
- Backpressure: same frame, out_ready toggled 1,0,0,1 repeating.
  -> window sequence identical to the first scenario.
  -> outputs stable during every out_ready=0 cycle.
  -> no pixel lost; in_ready drops when the output slot is full.
- Reset mid-frame: assert rst_n low after 7 accepted pixels, release, then send a full 4x3 frame.
  -> out_valid=0 during reset.
  -> exactly 12 windows after release, matching the first scenario.
- Throughput: defaults 256x256, continuous in_valid and out_ready, random pixels checked against a scoreboard model.
  -> 65536 windows, all matching.
  -> total cycle count <= 65536+256+256+4.
- Back-to-back frames: send two 4x3 frames, pad_mode=0 then 1, with in_valid held high.
  -> second frame's pixels accepted only after the first frame's out_last transfer.
  -> second frame's windows match the replicate-mode values.
